// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths and responder FSM encoding
package wb_pkg;

    localparam int WB_ADR_W   = 30;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/sram_1rw_be.sv
// rtl/sram_1rw_be.sv - single-port word array, byte write enables, registered read
module sram_1rw_be
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd_en,
    input  logic [WB_SEL_W-1:0]   wr_be,
    input  logic [WB_DAT_W-1:0]   wdata,
    output logic [WB_DAT_W-1:0]   rdata
);

    logic [WB_DAT_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_SEL_W; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone classic SRAM responder with wait states and window decode
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WB_ADR_W-1:0] wb_ADR,
    input  logic [WB_DAT_W-1:0] wb_DAT_MOSI,
    input  logic [WB_SEL_W-1:0] wb_SEL,
    input  logic                wb_CYC,
    input  logic                wb_STB,
    input  logic                wb_WE,
    output logic [WB_DAT_W-1:0] wb_DAT_MISO,
    output logic                wb_ACK,
    output logic                wb_ERR
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    wb_state_t             state, next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic                  we_q;
    logic [WB_DAT_W-1:0]   dat_q;

    logic req;
    logic hit;
    logic rd_en;
    logic [WB_SEL_W-1:0] wr_be;

    assign req = wb_CYC & wb_STB;
    assign hit = (wb_ADR[WB_ADR_W-1:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = hit ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    next_state = ST_IDLE;
                end else if (wait_cnt == '0) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            wb_ACK   <= 1'b0;
            wb_ERR   <= 1'b0;
        end else begin
            state  <= next_state;
            wb_ACK <= (next_state == ST_RESP);
            wb_ERR <= (next_state == ST_ERR);
            if (state == ST_IDLE && req && hit) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req && hit) begin
            adr_q <= wb_ADR[ADDR_WIDTH-1:0];
            sel_q <= wb_SEL;
            we_q  <= wb_WE;
            dat_q <= wb_DAT_MOSI;
        end
    end

    // Read on the last WAIT cycle so registered data lines up with ACK in RESP.
    assign rd_en = (state == ST_WAIT) && req && (wait_cnt == '0) && !we_q;
    assign wr_be = (state == ST_RESP && we_q && !reset) ? sel_q : '0;

    sram_1rw_be #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .reset (reset),
        .addr  (adr_q),
        .rd_en (rd_en),
        .wr_be (wr_be),
        .wdata (dat_q),
        .rdata (wb_DAT_MISO)
    );

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - self-checking bench for wb_sram_slave across three configurations
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    int          dsel;
    logic [2:0]  cyc_v, ack_v, err_v;
    logic [31:0] miso [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdata [bit [31:0]];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    assign cyc_v[0] = cyc && (dsel == 0);
    assign cyc_v[1] = cyc && (dsel == 1);
    assign cyc_v[2] = cyc && (dsel == 2);

    wb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .wb_ADR(adr), .wb_DAT_MOSI(dat), .wb_SEL(sel),
        .wb_CYC(cyc_v[0]), .wb_STB(stb), .wb_WE(we),
        .wb_DAT_MISO(miso[0]), .wb_ACK(ack_v[0]), .wb_ERR(err_v[0]));

    wb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .wb_ADR(adr), .wb_DAT_MOSI(dat), .wb_SEL(sel),
        .wb_CYC(cyc_v[1]), .wb_STB(stb), .wb_WE(we),
        .wb_DAT_MISO(miso[1]), .wb_ACK(ack_v[1]), .wb_ERR(err_v[1]));

    wb_sram_slave #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(5)) dut2 (
        .clk(clk), .reset(reset), .wb_ADR(adr), .wb_DAT_MOSI(dat), .wb_SEL(sel),
        .wb_CYC(cyc_v[2]), .wb_STB(stb), .wb_WE(we),
        .wb_DAT_MISO(miso[2]), .wb_ACK(ack_v[2]), .wb_ERR(err_v[2]));

    function automatic int ws(input int k);
        case (k)
            0: return 0;
            1: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int aw(input int k);
        return (k == 2) ? 8 : 12;
    endfunction

    function automatic logic [31:0] base(input int k);
        case (k)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            default: return 32'h0001_0000;
        endcase
    endfunction

    function automatic logic [29:0] base_w(input int k);
        logic [31:0] b;
        b = base(k) >> 2;
        return b[29:0];
    endfunction

    function automatic bit is_hit(input int k, input logic [29:0] a);
        return ({2'b00, a} >> aw(k)) == (base(k) >> (aw(k) + 2));
    endfunction

    function automatic bit [31:0] key(input int k, input logic [29:0] a);
        bit [1:0] kk;
        kk = 2'(k);
        return {kk, a};
    endfunction

    task automatic model_write(input int k, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = mdata.exists(key(k, a)) ? mdata[key(k, a)] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        end
        mdata[key(k, a)] = v;
    endtask

    task automatic bus_access(input int k, input logic [29:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input int drop_at,
                              output int ack_cyc, output int err_cyc, output logic [31:0] rd, output bit bad);
        int stop_at;
        ack_cyc = -1; err_cyc = -1; rd = '0; bad = 1'b0; stop_at = 24;
        @(posedge clk); #1;
        dsel = k; adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        for (int n = 1; n <= stop_at; n++) begin
            @(posedge clk); #1;
            if (n == drop_at) begin cyc = 1'b0; stb = 1'b0; end
            for (int j = 0; j < 3; j++) begin
                if (j != k && (ack_v[j] || err_v[j])) bad = 1'b1;
            end
            if (ack_v[k] && err_v[k]) bad = 1'b1;
            if (ack_v[k] || err_v[k]) begin
                if (ack_cyc >= 0 || err_cyc >= 0) begin
                    bad = 1'b1;
                end else begin
                    if (ack_v[k]) ack_cyc = n; else err_cyc = n;
                    rd = miso[k];
                    cyc = 1'b0; stb = 1'b0;
                    stop_at = n + 3;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; dsel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ack_v[k], err_v[k], miso[k]} !== 34'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d: ack=%b err=%b miso=%h, required 0/0/00000000", k, ack_v[k], err_v[k], miso[k]);
            end
            last_rd[k] = 32'h0;
        end
        reset = 1'b0;
    endtask

    task automatic test_preload();
        int ac, ec; logic [31:0] rd, d; bit bad;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 48; i++) begin
                d = $urandom;
                bus_access(k, base_w(k) + 30'(i), 1'b1, d, 4'hF, 0, ac, ec, rd, bad);
                checks++;
                if (ac != 2 + ws(k) || ec != -1 || bad || rd !== last_rd[k]) begin
                    failures++;
                    $display("FAIL preload dut%0d idx%0d: ack_cyc=%0d err_cyc=%0d bad=%0d miso=%h, required ack_cyc=%0d err_cyc=-1 bad=0 miso=%h",
                             k, i, ac, ec, bad, rd, 2 + ws(k), last_rd[k]);
                end
                model_write(k, base_w(k) + 30'(i), d, 4'hF);
            end
        end
    endtask

    task automatic test_write_read();
        int ac, ec; logic [31:0] rd; bit bad;
        bus_access(0, 30'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 2 || ec != -1 || bad) begin
            failures++;
            $display("FAIL write_latency: ack_cyc=%0d err_cyc=%0d bad=%0d, required 2/-1/0", ac, ec, bad);
        end
        model_write(0, 30'h10, 32'hDEADBEEF, 4'hF);
        bus_access(0, 30'h10, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 2 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_back: ack_cyc=%0d data=%h, required 2/deadbeef", ac, rd);
        end
        last_rd[0] = 32'hDEADBEEF;
    endtask

    task automatic test_byte_lanes();
        int ac, ec; logic [31:0] rd; bit bad;
        bus_access(0, 30'h10, 1'b1, 32'h11223344, 4'hF, 0, ac, ec, rd, bad);
        model_write(0, 30'h10, 32'h11223344, 4'hF);
        bus_access(0, 30'h10, 1'b1, 32'hAABBCCDD, 4'b0101, 0, ac, ec, rd, bad);
        model_write(0, 30'h10, 32'hAABBCCDD, 4'b0101);
        bus_access(0, 30'h10, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 2 || rd !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL byte_lanes: ack_cyc=%0d data=%h, required 2/11bb33dd", ac, rd);
        end
        last_rd[0] = rd;
        bus_access(0, 30'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 2 || ec != -1 || bad) begin
            failures++;
            $display("FAIL sel_zero_ack: ack_cyc=%0d err_cyc=%0d bad=%0d, required 2/-1/0", ac, ec, bad);
        end
        bus_access(0, 30'h10, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (rd !== mdata[key(0, 30'h10)]) begin
            failures++;
            $display("FAIL sel_zero_unchanged: data=%h, required %h", rd, mdata[key(0, 30'h10)]);
        end
        last_rd[0] = mdata[key(0, 30'h10)];
    endtask

    task automatic test_wait_states();
        int ac, ec; logic [31:0] rd; bit bad;
        bus_access(1, base_w(1) + 30'd5, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 5 || ec != -1 || bad) begin
            failures++;
            $display("FAIL wait_states: ack_cyc=%0d err_cyc=%0d bad=%0d, required 5/-1/0", ac, ec, bad);
        end
        checks++;
        if (rd !== mdata[key(1, base_w(1) + 30'd5)]) begin
            failures++;
            $display("FAIL wait_states_data: data=%h, required %h", rd, mdata[key(1, base_w(1) + 30'd5)]);
        end
        last_rd[1] = mdata[key(1, base_w(1) + 30'd5)];
    endtask

    task automatic test_out_of_range();
        int ac, ec; logic [31:0] rd; bit bad;
        bus_access(1, 30'h0, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ec != 1 || ac != -1 || bad || rd !== last_rd[1]) begin
            failures++;
            $display("FAIL out_of_range: err_cyc=%0d ack_cyc=%0d bad=%0d miso=%h, required 1/-1/0/%h", ec, ac, bad, rd, last_rd[1]);
        end
    endtask

    task automatic test_abort();
        int ac, ec; logic [31:0] rd, old; bit bad;
        old = mdata[key(2, base_w(2) + 30'h20)];
        bus_access(2, base_w(2) + 30'h20, 1'b1, 32'h12345678, 4'hF, 3, ac, ec, rd, bad);
        checks++;
        if (ac != -1 || ec != -1 || bad) begin
            failures++;
            $display("FAIL abort_no_resp: ack_cyc=%0d err_cyc=%0d bad=%0d, required -1/-1/0", ac, ec, bad);
        end
        bus_access(2, base_w(2) + 30'h20, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 7 || rd !== old) begin
            failures++;
            $display("FAIL abort_no_write: ack_cyc=%0d data=%h, required 7/%h", ac, rd, old);
        end
        last_rd[2] = old;
    endtask

    task automatic test_back_to_back();
        int ack_at [3];
        logic [31:0] got [3];
        int na;
        na = 0;
        for (int i = 0; i < 3; i++) ack_at[i] = -1;
        @(posedge clk); #1;
        dsel = 0; we = 1'b0; sel = 4'hF; adr = 30'd1; cyc = 1'b1; stb = 1'b1;
        for (int n = 1; n <= 20 && na < 3; n++) begin
            @(posedge clk); #1;
            if (ack_v[0]) begin
                ack_at[na] = n;
                got[na] = miso[0];
                na++;
                if (na < 3) adr = 30'(na + 1);
                else begin cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack_at[i] != 2 + 3 * i || got[i] !== mdata[key(0, 30'(i + 1))]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: ack_cyc=%0d data=%h, required %0d/%h",
                         i, ack_at[i], got[i], 2 + 3 * i, mdata[key(0, 30'(i + 1))]);
            end
        end
        last_rd[0] = mdata[key(0, 30'd3)];
    endtask

    task automatic test_reset_mid_op();
        int ac, ec; logic [31:0] rd, old; bit bad;
        old = mdata[key(1, base_w(1) + 30'd7)];
        @(posedge clk); #1;
        dsel = 1; adr = base_w(1) + 30'd7; we = 1'b1; dat = 32'hCAFEF00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cyc = 1'b0; stb = 1'b0;
        checks++;
        if (ack_v !== 3'b000 || err_v !== 3'b000 || miso[1] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_op_outputs: ack=%b err=%b miso=%h, required 000/000/00000000", ack_v, err_v, miso[1]);
        end
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        bus_access(1, base_w(1) + 30'd7, 1'b0, 32'h0, 4'hF, 0, ac, ec, rd, bad);
        checks++;
        if (ac != 5 || rd !== old || bad) begin
            failures++;
            $display("FAIL reset_mid_op_data: ack_cyc=%0d data=%h bad=%0d, required 5/%h/0", ac, rd, bad, old);
        end
        last_rd[1] = old;
    endtask

    task automatic test_random();
        int ac, ec, k, idx, drop, r; logic [31:0] rd, d, exp; logic [29:0] a; logic [3:0] s; bit bad, w, miss;
        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, 2);
            idx = $urandom_range(0, 47);
            miss = ($urandom_range(0, 4) == 0);
            a = base_w(k) + 30'(idx);
            if (miss) begin
                r = $urandom_range(0, 29 - aw(k));
                a[aw(k) + r] = ~a[aw(k) + r];
            end
            w = $urandom_range(0, 1);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            drop = (!miss && $urandom_range(0, 5) == 0) ? $urandom_range(1, ws(k) + 1) : 0;
            bus_access(k, a, w, d, s, drop, ac, ec, rd, bad);
            checks++;
            if (drop != 0) begin
                if (ac != -1 || ec != -1 || bad) begin
                    failures++;
                    $display("FAIL rand_abort it%0d dut%0d: ack_cyc=%0d err_cyc=%0d bad=%0d, required -1/-1/0", it, k, ac, ec, bad);
                end
            end else if (is_hit(k, a)) begin
                exp = w ? last_rd[k] : mdata[key(k, a)];
                if (ac != 2 + ws(k) || ec != -1 || bad || rd !== exp) begin
                    failures++;
                    $display("FAIL rand_hit it%0d dut%0d we=%0d: ack_cyc=%0d err_cyc=%0d bad=%0d data=%h, required %0d/-1/0/%h",
                             it, k, w, ac, ec, bad, rd, 2 + ws(k), exp);
                end
                if (w) model_write(k, a, d, s);
                else last_rd[k] = exp;
            end else begin
                if (ec != 1 || ac != -1 || bad || rd !== last_rd[k]) begin
                    failures++;
                    $display("FAIL rand_miss it%0d dut%0d: err_cyc=%0d ack_cyc=%0d bad=%0d miso=%h, required 1/-1/0/%h",
                             it, k, ec, ac, bad, rd, last_rd[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
